// File: rtl/junction_sensor_ctrl.sv
// junction_sensor_ctrl: main road plus NUM_SIDE sensor-actuated side roads, side roads served round-robin.
// Latency: lights, count and phase are registered; a phase of duration D holds for exactly D cycles.
// Backpressure: none; SENSOR pulses are latched into pending and served in round-robin order.
//
// Ports:
//   clk          system clock (1 cycle = 1 s)
//   rst          synchronous reset, active-high
//   SENSOR       vehicle present, one bit per side road
//   main_road1   main road 1 light {R,Y,G}
//   main_road1T  main road 1 protected-turn light {R,Y,G}
//   main_road2   main road 2 light {R,Y,G}
//   side_road    side road lights, side i at [3i+2:3i]
//   count        cycles remaining in the current phase
//   phase        current state encoding (debug)
//
// Optional feature macro: SIDE_GREEN_EXTEND_EN
//   When defined, a side green is extended by EXT_TIME (up to MAX_EXT times)
//   while the served side's sensor is still active at the last green cycle.
module junction_sensor_ctrl #(
  parameter int NUM_SIDE       = 2,
  parameter int COUNT_W        = 8,
  parameter int MAIN_MIN_GREEN = 60,
  parameter int TURN_TIME      = 10,
  parameter int SIDE_GREEN     = 20,
  parameter int YELLOW_TIME    = 3,
  parameter int ALL_RED_TIME   = 2,
  parameter int EXT_TIME       = 5,
  parameter int MAX_EXT        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SIDE-1:0]   SENSOR,
  output logic [2:0]            main_road1,
  output logic [2:0]            main_road1T,
  output logic [2:0]            main_road2,
  output logic [3*NUM_SIDE-1:0] side_road,
  output logic [COUNT_W-1:0]    count,
  output logic [2:0]            phase
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  localparam longint LIMIT = longint'(1) << COUNT_W;

  if (NUM_SIDE < 1 || NUM_SIDE > 8) begin : g_err_num_side
    $error("junction_sensor_ctrl: NUM_SIDE must be within 1..8");
  end
  if (longint'(MAIN_MIN_GREEN) >= LIMIT || MAIN_MIN_GREEN < 1) begin : g_err_main
    $error("junction_sensor_ctrl: MAIN_MIN_GREEN out of range");
  end
  if (longint'(TURN_TIME) >= LIMIT || TURN_TIME < 0) begin : g_err_turn
    $error("junction_sensor_ctrl: TURN_TIME out of range");
  end
  if (longint'(SIDE_GREEN) >= LIMIT || SIDE_GREEN < 1) begin : g_err_side
    $error("junction_sensor_ctrl: SIDE_GREEN out of range");
  end
  if (longint'(YELLOW_TIME) >= LIMIT || YELLOW_TIME < 1) begin : g_err_yellow
    $error("junction_sensor_ctrl: YELLOW_TIME out of range");
  end
  if (longint'(ALL_RED_TIME) >= LIMIT || ALL_RED_TIME < 1) begin : g_err_allred
    $error("junction_sensor_ctrl: ALL_RED_TIME out of range");
  end
  if (longint'(EXT_TIME) >= LIMIT || EXT_TIME < 1) begin : g_err_ext
    $error("junction_sensor_ctrl: EXT_TIME out of range");
  end
  if (longint'(MAX_EXT) >= LIMIT || MAX_EXT < 0) begin : g_err_maxext
    $error("junction_sensor_ctrl: MAX_EXT out of range");
  end

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  localparam int SEL_W = (NUM_SIDE > 1) ? $clog2(NUM_SIDE) : 1;

  typedef enum logic [2:0] {
    S_MAIN_G  = 3'd0,
    S_MAIN2_Y = 3'd1,
    S_TURN_G  = 3'd2,
    S_TURN_Y  = 3'd3,
    S_SIDE_G  = 3'd4,
    S_SIDE_Y  = 3'd5,
    S_ALL_R   = 3'd6
  } state_t;

  typedef struct packed {
    logic [2:0]            m1;
    logic [2:0]            m1t;
    logic [2:0]            m2;
    logic [3*NUM_SIDE-1:0] side;
  } lights_t;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  localparam logic [COUNT_W-1:0] C_ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] C_MAIN = COUNT_W'(MAIN_MIN_GREEN);
  localparam logic [COUNT_W-1:0] C_TURN = COUNT_W'(TURN_TIME);
  localparam logic [COUNT_W-1:0] C_SIDE = COUNT_W'(SIDE_GREEN);
  localparam logic [COUNT_W-1:0] C_YEL  = COUNT_W'(YELLOW_TIME);
  localparam logic [COUNT_W-1:0] C_ALLR = COUNT_W'(ALL_RED_TIME);

  // With TURN_TIME == 0 the protected turn green is skipped entirely.
  localparam state_t             S_AFTER_M2Y = (TURN_TIME == 0) ? S_TURN_Y : S_TURN_G;
  localparam logic [COUNT_W-1:0] C_AFTER_M2Y = (TURN_TIME == 0) ? C_YEL : C_TURN;

`ifdef SIDE_GREEN_EXTEND_EN
  localparam int                 EXT_W = (MAX_EXT < 1) ? 1 : $clog2(MAX_EXT + 1);
  localparam logic [COUNT_W-1:0] C_EXT = COUNT_W'(EXT_TIME);
`endif

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [NUM_SIDE-1:0] f_oh(input logic [SEL_W-1:0] sel);
    return NUM_SIDE'(1) << sel;
  endfunction

  // First requesting side strictly after ptr, searching cyclically upward.
  function automatic logic [SEL_W-1:0] f_rr(input logic [NUM_SIDE-1:0] req,
                                            input logic [SEL_W-1:0]    ptr);
    logic [SEL_W-1:0] res;
    logic [SEL_W-1:0] idx;
    logic             found;
    res   = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_SIDE; k++) begin
      idx = SEL_W'((int'(ptr) + k) % NUM_SIDE);
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic lights_t f_lights(input state_t s, input logic [SEL_W-1:0] sel);
    lights_t l;
    l.m1   = L_RED;
    l.m1t  = L_RED;
    l.m2   = L_RED;
    l.side = {NUM_SIDE{L_RED}};
    case (s)
      S_MAIN_G:  begin l.m1 = L_GRN; l.m2 = L_GRN; end
      S_MAIN2_Y: begin l.m1 = L_GRN; l.m2 = L_YEL; end
      S_TURN_G:  begin l.m1 = L_GRN; l.m1t = L_GRN; end
      S_TURN_Y:  begin l.m1 = L_YEL; l.m1t = L_YEL; end
      S_SIDE_G:  l.side[3*int'(sel) +: 3] = L_GRN;
      S_SIDE_Y:  l.side[3*int'(sel) +: 3] = L_YEL;
      default:   ;
    endcase
    return l;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [COUNT_W-1:0]  r_count;
  logic [NUM_SIDE-1:0] r_pending;
  logic [SEL_W-1:0]    r_rr;
  logic [SEL_W-1:0]    r_sel;
  lights_t             r_lt;
`ifdef SIDE_GREEN_EXTEND_EN
  logic [EXT_W-1:0]    r_ext_cnt;
  logic                w_ext_ok;
`endif

  logic                w_entering_side;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic [NUM_SIDE-1:0] w_set;
  logic [NUM_SIDE-1:0] w_clr;
  logic [NUM_SIDE-1:0] w_pending_nxt;

  assign w_entering_side = (r_state == S_TURN_Y) && (r_count <= C_ONE);
  assign w_sel_nxt       = f_rr(r_pending, r_rr);

  // The side currently in green cannot re-request itself; a request arriving
  // on the entry edge is swallowed by the clear.
  assign w_set         = SENSOR & ~((r_state == S_SIDE_G) ? f_oh(r_sel) : '0);
  assign w_clr         = w_entering_side ? f_oh(w_sel_nxt) : '0;
  assign w_pending_nxt = (r_pending | w_set) & ~w_clr;

`ifdef SIDE_GREEN_EXTEND_EN
  assign w_ext_ok = (|(SENSOR & f_oh(r_sel))) && (r_ext_cnt < EXT_W'(MAX_EXT));
`endif

  // ---------------------------------------------------------------------------
  // Phase sequencer with registered light outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_MAIN_G;
      r_count   <= C_MAIN;
      r_pending <= '0;
      r_rr      <= SEL_W'(NUM_SIDE - 1);
      r_sel     <= '0;
      r_lt      <= f_lights(S_MAIN_G, '0);
`ifdef SIDE_GREEN_EXTEND_EN
      r_ext_cnt <= '0;
`endif
    end else begin
      r_pending <= w_pending_nxt;
      case (r_state)
        S_MAIN_G: begin
          // Main green never ends before its minimum, then waits for a request.
          if ((r_count <= C_ONE) && (|r_pending)) begin
            r_state <= S_MAIN2_Y;
            r_count <= C_YEL;
            r_lt    <= f_lights(S_MAIN2_Y, r_sel);
          end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end
        end
        S_MAIN2_Y: begin
          if (r_count <= C_ONE) begin
            r_state <= S_AFTER_M2Y;
            r_count <= C_AFTER_M2Y;
            r_lt    <= f_lights(S_AFTER_M2Y, r_sel);
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        S_TURN_G: begin
          if (r_count <= C_ONE) begin
            r_state <= S_TURN_Y;
            r_count <= C_YEL;
            r_lt    <= f_lights(S_TURN_Y, r_sel);
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        S_TURN_Y: begin
          if (r_count <= C_ONE) begin
            r_state <= S_SIDE_G;
            r_count <= C_SIDE;
            r_sel   <= w_sel_nxt;
            r_rr    <= w_sel_nxt;
            r_lt    <= f_lights(S_SIDE_G, w_sel_nxt);
`ifdef SIDE_GREEN_EXTEND_EN
            r_ext_cnt <= '0;
`endif
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        S_SIDE_G: begin
          if (r_count > C_ONE) begin
            r_count <= r_count - 1'b1;
`ifdef SIDE_GREEN_EXTEND_EN
          end else if (w_ext_ok) begin
            // Vehicle still present: stay green for another EXT_TIME.
            r_count   <= C_EXT;
            r_ext_cnt <= r_ext_cnt + 1'b1;
`endif
          end else begin
            r_state <= S_SIDE_Y;
            r_count <= C_YEL;
            r_lt    <= f_lights(S_SIDE_Y, r_sel);
          end
        end
        S_SIDE_Y: begin
          if (r_count <= C_ONE) begin
            r_state <= S_ALL_R;
            r_count <= C_ALLR;
            r_lt    <= f_lights(S_ALL_R, r_sel);
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        S_ALL_R: begin
          if (r_count <= C_ONE) begin
            r_state <= S_MAIN_G;
            r_count <= C_MAIN;
            r_lt    <= f_lights(S_MAIN_G, r_sel);
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        default: begin
          r_state <= S_MAIN_G;
          r_count <= C_MAIN;
          r_lt    <= f_lights(S_MAIN_G, r_sel);
        end
      endcase
    end
  end

  assign main_road1  = r_lt.m1;
  assign main_road1T = r_lt.m1t;
  assign main_road2  = r_lt.m2;
  assign side_road   = r_lt.side;
  assign count       = r_count;
  assign phase       = r_state;

endmodule

// File: tb/tb_junction_sensor_ctrl.sv
// tb_junction_sensor_ctrl: timeline checks plus a segment-based reference model for the junction controller.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; SENSOR driven directly.
module tb_junction_sensor_ctrl;

  localparam int NS  = 2;
  localparam int CW  = 8;
  localparam int MMG = 60;
  localparam int TT  = 10;
  localparam int SGT = 20;
  localparam int YT  = 3;
  localparam int ART = 2;
  localparam int ET  = 5;
  localparam int MX  = 2;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

`ifdef SIDE_GREEN_EXTEND_EN
  localparam int EXP_EXT_LEN = SGT + MX * ET;
`else
  localparam int EXP_EXT_LEN = SGT;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] sensor  = '0;
  logic [NS-1:0] sensor2 = '0;

  logic [2:0]      main_road1, main_road1T, main_road2;
  logic [3*NS-1:0] side_road;
  logic [CW-1:0]   count;
  logic [2:0]      phase;

  logic [2:0]      d2_m1, d2_m1t, d2_m2;
  logic [3*NS-1:0] d2_side;
  logic [CW-1:0]   d2_count;
  logic [2:0]      d2_phase;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  junction_sensor_ctrl #(
    .NUM_SIDE(NS), .COUNT_W(CW), .MAIN_MIN_GREEN(MMG), .TURN_TIME(TT),
    .SIDE_GREEN(SGT), .YELLOW_TIME(YT), .ALL_RED_TIME(ART), .EXT_TIME(ET), .MAX_EXT(MX)
  ) dut (
    .clk(clk), .rst(rst), .SENSOR(sensor),
    .main_road1(main_road1), .main_road1T(main_road1T), .main_road2(main_road2),
    .side_road(side_road), .count(count), .phase(phase)
  );

  junction_sensor_ctrl #(
    .NUM_SIDE(NS), .COUNT_W(CW), .MAIN_MIN_GREEN(MMG), .TURN_TIME(0),
    .SIDE_GREEN(SGT), .YELLOW_TIME(YT), .ALL_RED_TIME(ART), .EXT_TIME(ET), .MAX_EXT(MX)
  ) dut2 (
    .clk(clk), .rst(rst), .SENSOR(sensor2),
    .main_road1(d2_m1), .main_road1T(d2_m1t), .main_road2(d2_m2),
    .side_road(d2_side), .count(d2_count), .phase(d2_phase)
  );

  // ---------------------------------------------------------------------------
  // Reference model: the junction as a sequence of timed segments. Each segment
  // has a duration and an elapsed time; remaining time = duration - elapsed.
  // ---------------------------------------------------------------------------
  localparam int K_MG = 0, K_M2Y = 1, K_TG = 2, K_TY = 3, K_SG = 4, K_SY = 5, K_AR = 6;

  int          m_seg, m_el, m_dur, m_rr, m_sel, m_ext;
  logic [NS-1:0] m_pend;

  function automatic int seg_dur(input int s);
    case (s)
      K_MG:  return MMG;
      K_TG:  return TT;
      K_SG:  return SGT;
      K_AR:  return ART;
      default: return YT;
    endcase
  endfunction

  function automatic int seg_next(input int s);
    case (s)
      K_MG:  return K_M2Y;
      K_M2Y: return (TT == 0) ? K_TY : K_TG;
      K_TG:  return K_TY;
      K_TY:  return K_SG;
      K_SG:  return K_SY;
      K_SY:  return K_AR;
      default: return K_MG;
    endcase
  endfunction

  function automatic int m_remaining();
    if (m_seg == K_MG) return (MMG - m_el > 0) ? (MMG - m_el) : 0;
    return m_dur - m_el;
  endfunction

  function automatic logic [2:0] exp_m1();
    if (m_seg == K_MG || m_seg == K_M2Y || m_seg == K_TG) return G;
    if (m_seg == K_TY) return Y;
    return R;
  endfunction

  function automatic logic [2:0] exp_t();
    if (m_seg == K_TG) return G;
    if (m_seg == K_TY) return Y;
    return R;
  endfunction

  function automatic logic [2:0] exp_m2();
    if (m_seg == K_MG) return G;
    if (m_seg == K_M2Y) return Y;
    return R;
  endfunction

  function automatic logic [3*NS-1:0] exp_side();
    logic [3*NS-1:0] v;
    for (int i = 0; i < NS; i++) begin
      if (m_seg == K_SG && m_sel == i)      v[3*i +: 3] = G;
      else if (m_seg == K_SY && m_sel == i) v[3*i +: 3] = Y;
      else                                  v[3*i +: 3] = R;
    end
    return v;
  endfunction

  task automatic model_step();
    int            rem;
    logic [NS-1:0] old_pend;
    logic [NS-1:0] setm;
    logic          leave;
    logic          found;
    int            cand;
    if (rst) begin
      m_seg = K_MG; m_el = 0; m_dur = MMG; m_pend = '0;
      m_rr = NS - 1; m_sel = 0; m_ext = 0;
      return;
    end
    rem      = m_remaining();
    old_pend = m_pend;
    setm     = sensor;
    if (m_seg == K_SG) setm[m_sel] = 1'b0;
    leave = 1'b0;
    if (m_seg == K_MG) begin
      leave = (rem <= 1) && (old_pend != 0);
    end else if (rem == 1) begin
`ifdef SIDE_GREEN_EXTEND_EN
      if (m_seg == K_SG && sensor[m_sel] && m_ext < MX) begin
        m_dur = m_dur + ET;
        m_ext = m_ext + 1;
      end else
`endif
      leave = 1'b1;
    end
    m_pend = m_pend | setm;
    if (leave) begin
      m_seg = seg_next(m_seg);
      m_el  = 0;
      m_dur = seg_dur(m_seg);
      if (m_seg == K_SG) begin
        found = 1'b0;
        for (int k = 1; k <= NS; k++) begin
          cand = (m_rr + k) % NS;
          if (!found && old_pend[cand]) begin
            m_sel = cand;
            found = 1'b1;
          end
        end
        m_rr = m_sel;
        m_ext = 0;
        m_pend[m_sel] = 1'b0;
      end
    end else begin
      m_el = m_el + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    sensor = '0; sensor2 = '0;
    do_reset();
    n_cmp++; if (main_road1 !== G) begin n_err++; $display("FAIL reset_m1: got %b want %b", main_road1, G); end
    n_cmp++; if (main_road2 !== G) begin n_err++; $display("FAIL reset_m2: got %b want %b", main_road2, G); end
    n_cmp++; if (main_road1T !== R) begin n_err++; $display("FAIL reset_m1T: got %b want %b", main_road1T, R); end
    n_cmp++; if (side_road !== {NS{R}}) begin n_err++; $display("FAIL reset_side: got %b want %b", side_road, {NS{R}}); end
    n_cmp++; if (count !== CW'(MMG)) begin n_err++; $display("FAIL reset_count: got %0d want %0d", count, MMG); end
    n_cmp++; if (d2_count !== CW'(MMG)) begin n_err++; $display("FAIL reset_count_dut2: got %0d want %0d", d2_count, MMG); end
  endtask

  task automatic test_idle();
    int bad = 0;
    sensor = '0;
    for (int t = 1; t <= 200; t++) begin
      tick();
      n_cmp++;
      if (main_road1 !== G || main_road2 !== G || main_road1T !== R || side_road !== {NS{R}}
          || int'(count) !== m_remaining()) begin
        n_err++; bad++;
        if (bad < 10)
          $display("FAIL idle t=%0d: got m1=%b m2=%b t=%b side=%b cnt=%0d want cnt=%0d",
                   t, main_road1, main_road2, main_road1T, side_road, count, m_remaining());
      end
    end
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL idle_hold0: got %0d want 0", count); end
  endtask

  task automatic test_single_request();
    logic [2:0] e1, et, e2, es0;
    int         ec;
    do_reset();
    for (int t = 1; t <= 110; t++) begin
      sensor = (t == 10) ? 2'b01 : 2'b00;
      tick();
      if (t < 60)       begin e1 = G; et = R; e2 = G; es0 = R; ec = MMG - t; end
      else if (t < 63)  begin e1 = G; et = R; e2 = Y; es0 = R; ec = 63 - t; end
      else if (t < 73)  begin e1 = G; et = G; e2 = R; es0 = R; ec = 73 - t; end
      else if (t < 76)  begin e1 = Y; et = Y; e2 = R; es0 = R; ec = 76 - t; end
      else if (t < 96)  begin e1 = R; et = R; e2 = R; es0 = G; ec = 96 - t; end
      else if (t < 99)  begin e1 = R; et = R; e2 = R; es0 = Y; ec = 99 - t; end
      else if (t < 101) begin e1 = R; et = R; e2 = R; es0 = R; ec = 101 - t; end
      else              begin e1 = G; et = R; e2 = G; es0 = R; ec = MMG - (t - 101); end
      n_cmp++;
      if (main_road1 !== e1 || main_road1T !== et || main_road2 !== e2
          || side_road !== {R, es0} || int'(count) !== ec) begin
        n_err++;
        $display("FAIL single_req t=%0d: got %b/%b/%b side=%b cnt=%0d want %b/%b/%b side=%b cnt=%0d",
                 t, main_road1, main_road1T, main_road2, side_road, count, e1, et, e2, {R, es0}, ec);
      end
    end
    sensor = '0;
  endtask

  task automatic test_both_held();
    int  first_side = -1, second_side = -1;
    int  first_t = -1, second_t = -1;
    int  mg_run = 0, mg_max = 0;
    logic [3*NS-1:0] prev_side;
    sensor = 2'b11;
    do_reset();
    prev_side = side_road;
    for (int t = 1; t <= 400 && second_t < 0; t++) begin
      tick();
      if (first_t >= 0 && main_road1 === G && main_road2 === G) begin
        mg_run++; if (mg_run > mg_max) mg_max = mg_run;
      end else begin
        mg_run = 0;
      end
      for (int i = 0; i < NS; i++) begin
        if (side_road[3*i +: 3] === G && prev_side[3*i +: 3] !== G) begin
          if (first_t < 0) begin first_t = t; first_side = i; end
          else if (second_t < 0) begin second_t = t; second_side = i; end
        end
      end
      prev_side = side_road;
    end
    n_cmp++; if (first_side !== 0 || first_t !== 76) begin n_err++;
      $display("FAIL both_first: got side %0d at t=%0d want side 0 at t=76", first_side, first_t); end
    n_cmp++; if (second_side !== 1 || second_t !== 177) begin n_err++;
      $display("FAIL both_second: got side %0d at t=%0d want side 1 at t=177", second_side, second_t); end
    n_cmp++; if (mg_max < MMG) begin n_err++;
      $display("FAIL both_main_gap: got %0d main green cycles want >= %0d", mg_max, MMG); end
    sensor = '0;
  endtask

  task automatic test_no_turn();
    int turn_green_seen = 0;
    sensor = '0; sensor2 = '0;
    do_reset();
    for (int t = 1; t <= 90; t++) begin
      sensor2 = (t == 10) ? 2'b01 : 2'b00;
      tick();
      if (d2_m1t === G) turn_green_seen++;
      if (t == 62) begin
        n_cmp++; if (d2_m2 !== Y || d2_count !== CW'(1)) begin n_err++;
          $display("FAIL noturn_m2y: got m2=%b cnt=%0d want %b cnt=1", d2_m2, d2_count, Y); end
      end
      if (t == 63) begin
        n_cmp++; if (d2_m1t !== Y || d2_m1 !== Y || d2_m2 !== R || d2_count !== CW'(YT)) begin n_err++;
          $display("FAIL noturn_direct_ty: got m1=%b T=%b m2=%b cnt=%0d want %b/%b/%b cnt=%0d",
                   d2_m1, d2_m1t, d2_m2, d2_count, Y, Y, R, YT); end
      end
      if (t == 66) begin
        n_cmp++; if (d2_side !== {R, G} || d2_count !== CW'(SGT)) begin n_err++;
          $display("FAIL noturn_side_g: got side=%b cnt=%0d want %b cnt=%0d", d2_side, d2_count, {R, G}, SGT); end
      end
    end
    n_cmp++; if (turn_green_seen != 0) begin n_err++;
      $display("FAIL noturn_T_green: got %0d cycles of turn green want 0", turn_green_seen); end
    sensor2 = '0;
  endtask

  task automatic test_reset_mid_turn();
    logic found = 1'b0;
    do_reset();
    sensor = 2'b01;
    tick();
    sensor = '0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (main_road1T === G && count === CW'(4)) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL midreset_reach: got no TURN_G count=4 want reached"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (main_road1 !== G || main_road2 !== G || main_road1T !== R || side_road !== {NS{R}}) begin
      n_err++; $display("FAIL midreset_lights: got %b/%b/%b side=%b want %b/%b/%b side=%b",
                        main_road1, main_road1T, main_road2, side_road, G, R, G, {NS{R}}); end
    n_cmp++; if (count !== CW'(MMG)) begin n_err++; $display("FAIL midreset_count: got %0d want %0d", count, MMG); end
  endtask

  task automatic test_extend();
    int start_t = -1, len = 0;
    logic done = 1'b0;
    sensor = 2'b10;
    do_reset();
    for (int t = 1; t <= 200 && start_t < 0; t++) begin
      tick();
      if (side_road[5:3] === G) start_t = t;
    end
    n_cmp++; if (start_t !== 76) begin n_err++; $display("FAIL extend_start: got t=%0d want 76", start_t); end
    if (start_t >= 0) len = 1;
    for (int i = 0; i < 100 && start_t >= 0 && !done; i++) begin
      tick();
      if (side_road[5:3] === G) len++;
      else done = 1'b1;
    end
    n_cmp++; if (len != EXP_EXT_LEN) begin n_err++; $display("FAIL extend_len: got %0d want %0d", len, EXP_EXT_LEN); end
    n_cmp++; if (side_road !== {Y, R}) begin n_err++; $display("FAIL extend_then_yellow: got %b want %b", side_road, {Y, R}); end
    sensor = '0;
  endtask

  task automatic test_random();
    int bad = 0;
    sensor = '0;
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < NS; i++) sensor[i] = ($urandom_range(39) == 0);
      rst = ($urandom_range(1499) == 0);
      tick();
      n_cmp++;
      if (main_road1 !== exp_m1() || main_road1T !== exp_t() || main_road2 !== exp_m2()
          || side_road !== exp_side() || int'(count) !== m_remaining()) begin
        n_err++; bad++;
        if (bad < 20)
          $display("FAIL random t=%0d: got %b/%b/%b side=%b cnt=%0d want %b/%b/%b side=%b cnt=%0d",
                   t, main_road1, main_road1T, main_road2, side_road, count,
                   exp_m1(), exp_t(), exp_m2(), exp_side(), m_remaining());
      end
    end
    rst = 1'b0;
    sensor = '0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_request();
    test_both_held();
    test_no_turn();
    test_reset_mid_turn();
    test_extend();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/junction_sensor_ctrl.md
Name: junction_sensor_ctrl

Overview:
- Parametrised successor to the three-way sensor junction controller.
- Serves one main road (main_road1 with a protected turn, plus main_road2) and NUM_SIDE sensor-actuated side roads.
- Side roads are served round-robin from latched sensor requests; all phase durations are set by parameters.
- 1 clk cycle = 1 s, matching the existing junction benches; count reports the seconds remaining in the current phase.

Parameters:
- NUM_SIDE, 2, number of side roads (1..8).
- COUNT_W, 8, width of count and of all phase timers.
- MAIN_MIN_GREEN, 60, minimum main green in cycles.
- TURN_TIME, 10, protected-turn green in cycles; 0 skips the TURN_G phase.
- SIDE_GREEN, 20, side green in cycles.
- YELLOW_TIME, 3, every yellow phase in cycles.
- ALL_RED_TIME, 2, clearance before main green returns.
- EXT_TIME, 5, extension length in cycles (optional feature only).
- MAX_EXT, 2, maximum extensions per side green (optional feature only).

Ports:
- clk  in  1  system clock, 1 Hz nominal
- rst  in  1  synchronous reset, active-high
- SENSOR  in  NUM_SIDE  vehicle present, one bit per side road
- main_road1  out  3  light {R,Y,G}, one-hot
- main_road1T  out  3  turn light {R,Y,G}
- main_road2  out  3  light {R,Y,G}
- side_road  out  3*NUM_SIDE  light {R,Y,G} per side road; side i at bits [3i+2:3i]
- count  out  COUNT_W  cycles remaining in current phase
- phase  out  3  current state encoding (debug)

Behaviour:
Light encoding: 100 = red, 010 = yellow, 001 = green. Every output is always exactly one-hot.

Reset (rst=1 at posedge):
- state MAIN_G; main_road1 = main_road2 = 001; main_road1T = 100; all side_road = 100.
- count = MAIN_MIN_GREEN; pending = 0; rr_ptr = NUM_SIDE-1, so side 0 is served first.
- Reset asserted mid-phase aborts that phase on the same edge, with no yellow.

Phase timing rule:
- Entering a phase loads count with its duration D.
- While count > 1, count decrements each cycle.
- When count == 1, the next edge moves to the next state and loads its duration, so every timed phase lasts exactly D cycles.

States (m1 / T / m2 / side lights):
- MAIN_G (G/R/G/all R): count decrements to 0 and holds at 0. Exit on the edge where count <= 1 and pending != 0; next state MAIN2_Y.
- MAIN2_Y (G/R/Y/R), YELLOW_TIME: next TURN_G, or TURN_Y if TURN_TIME == 0.
- TURN_G (G/G/R/R), TURN_TIME: next TURN_Y.
- TURN_Y (Y/Y/R/R), YELLOW_TIME: next SIDE_G.
- SIDE_G (R/R/R/selected side G), SIDE_GREEN.
  - On entry: sel = first pending index after rr_ptr, searching cyclically upward; rr_ptr <= sel; pending[sel] cleared.
- SIDE_Y (selected side Y, all others R), YELLOW_TIME.
- ALL_R (all R), ALL_RED_TIME: next MAIN_G, which loads MAIN_MIN_GREEN.

Requests:
- pending[i] sets on any cycle with SENSOR[i]=1, except while state is SIDE_G with sel == i.
- Set and clear in the same cycle: clear wins for the side being entered.
- Only one side road is served per cycle through the sequence. Remaining pending bits persist to the next cycle, and MAIN_G still enforces MAIN_MIN_GREEN before serving them.
- A SENSOR pulse of one cycle is sufficient to register a request.

Elaboration:
- Any duration >= 2^COUNT_W, or NUM_SIDE outside 1..8, is an elaboration error (generate-time check).
- A duration of 0 is illegal except TURN_TIME.

Optional Feature:
Macro: SIDE_GREEN_EXTEND_EN
- Defined:
  - In SIDE_G, when count == 1 and SENSOR[sel] == 1 and ext_cnt < MAX_EXT, count reloads EXT_TIME and ext_cnt increments instead of moving to SIDE_Y.
  - ext_cnt clears on SIDE_G entry.
  - Maximum side green = SIDE_GREEN + MAX_EXT*EXT_TIME.
- Undefined: no ext_cnt register; SIDE_G is always exactly SIDE_GREEN cycles.

Test Plan:
1. Reset, SENSOR=0 for 200 cycles -> main_road1 = main_road2 = 001, side = 100, count 60 down to 0 then holds 0, phase stays MAIN_G.
2. SENSOR[0] pulsed 1 cycle at t=10 -> MAIN_G exits at t=60; then MAIN2_Y 3, TURN_G 10, TURN_Y 3, side0 green 20, side0 yellow 3, ALL_R 2, then MAIN_G with count=60; pending[0] reads 0 after SIDE_G entry.
3. SENSOR=2'b11 held from reset -> side 0 is served first, side 1 on the next cycle; the two side greens are separated by at least 60 cycles of main green.
4. TURN_TIME=0 instance, one request -> MAIN2_Y goes directly to TURN_Y; main_road1T is never 001.
5. rst asserted during TURN_G at count=4 -> on the next edge, reset values as listed; no yellow emitted.
6. SIDE_GREEN_EXTEND_EN defined, SENSOR[1] held high throughout -> side1 green lasts 20+5+5 = 30 cycles, then SIDE_Y. Same stimulus with the macro undefined -> 20 cycles.
